// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter/sequencer sharing one fpmult among N requesters.
// Qualifies the multiplier's held valid and recovers from a hang via watchdog.
module fpmult_arbiter #(
  parameter int P       = 8,
  parameter int Q       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N-1:0]     req_valid_in,
  output logic [N-1:0]     req_ready_out,
  input  logic [N*(P+Q)-1:0] req_x_in,
  input  logic [N*(P+Q)-1:0] req_y_in,
  input  logic [2*N-1:0]   req_round_in,
  output logic [N-1:0]     resp_valid_out,
  input  logic [N-1:0]     resp_ready_in,
  output logic [P+Q-1:0]   resp_p_out,
  output logic [3:0]       resp_oor_out,
  output logic             err_out,
  output logic             busy_out,
  output logic [P+Q-1:0]   fpm_x_out,
  output logic [P+Q-1:0]   fpm_y_out,
  output logic [1:0]       fpm_round_out,
  output logic             fpm_start_out,
  input  logic [P+Q-1:0]   fpm_p_in,
  input  logic [3:0]       fpm_oor_in,
  input  logic             fpm_valid_in,
  input  logic             fpm_ready_in
);

  localparam int W   = P + Q;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [W-1:0] QNAN =
    {1'b0, {Q{1'b1}}, 1'b1, {(P-2){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_g;
  logic [IW-1:0]  r_last;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [1:0]     r_rnd;
  logic [W-1:0]   r_p;
  logic [3:0]     r_oor;
  logic [WDW-1:0] r_wd;
  logic           r_err;

  logic [IW-1:0]  w_win;
  logic           w_found;
  logic           w_grant;
  logic           w_qual;
  logic           w_tmo;

  // Cyclic search starting one past the previous grant.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found &&
          req_valid_in[(int'(r_last) + k) % N]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_last) + k) % N);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_found &&
                   fpm_ready_in && !rst_in;

  // First WAIT cycle (wd == 0) still sees the previous op's held valid.
  assign w_qual = (r_state == S_WAIT) && fpm_valid_in &&
                  (r_wd != '0);
  assign w_tmo  = (r_state == S_WAIT) &&
                  (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_last  <= IW'(N - 1);
      r_x     <= '0;
      r_y     <= '0;
      r_rnd   <= '0;
      r_p     <= '0;
      r_oor   <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_x     <= req_x_in[w_win*W +: W];
            r_y     <= req_y_in[w_win*W +: W];
            r_rnd   <= req_round_in[w_win*2 +: 2];
            r_g     <= w_win;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (w_qual) begin
            r_p     <= fpm_p_in;
            r_oor   <= fpm_oor_in;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_p     <= QNAN;
            r_oor   <= 4'b0010;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready_in[r_g]) begin
            r_last  <= r_g;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_out  = w_grant ?
    ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;
  assign resp_valid_out = (r_state == S_RESP) ?
    ({{(N-1){1'b0}}, 1'b1} << r_g) : '0;
  assign resp_p_out     = r_p;
  assign resp_oor_out   = r_oor;
  assign err_out        = r_err;
  assign busy_out       = (r_state != S_IDLE);
  assign fpm_x_out      = r_x;
  assign fpm_y_out      = r_y;
  assign fpm_round_out  = r_rnd;
  assign fpm_start_out  = (r_state == S_ISSUE);

endmodule

// File: doc/fpmult_arbiter.md
# fpmult_arbiter

Round-robin arbiter and sequencer that shares one `fpmult` instance among N requesters. Each requester has a valid/ready request channel carrying operands and a rounding mode. Each also has a valid/ready response channel returning the product and the out-of-range flags. The block issues one multiplication at a time, qualifies the multiplier's held-valid output, and recovers from a hung multiplier with a watchdog.

## Interface
- P, 8, fraction field width plus one; W = P+Q is the word width
- Q, 8, exponent width
- N, 4, number of requesters (2..8)
- TIMEOUT, 64, maximum WAIT cycles before the watchdog fires (≥4)

- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-high reset
- req_valid_in  in  N  request valid, one bit per requester
- req_ready_out  out  N  request accepted (at most one bit high)
- req_x_in  in  N*W  operand X; requester i uses [i*W +: W]
- req_y_in  in  N*W  operand Y; same packing as req_x_in
- req_round_in  in  2N  rounding mode; requester i uses [2i +: 2]
- resp_valid_out  out  N  one-hot response valid
- resp_ready_in  in  N  response consumed
- resp_p_out  out  W  product, shared by all requesters
- resp_oor_out  out  4  out-of-range flags (bit0 SUB, bit1 NAN, bit2 INF, bit3 ZERO)
- err_out  out  1  one-cycle pulse when the watchdog fires
- busy_out  out  1  state ≠ IDLE
- fpm_x_out, fpm_y_out  out  W  multiplier operands
- fpm_round_out  out  2  multiplier rounding mode
- fpm_start_out  out  1  multiplier start
- fpm_p_in  in  W  multiplier product
- fpm_oor_in  in  4  multiplier out-of-range flags
- fpm_valid_in  in  1  multiplier output valid (held until the next start)
- fpm_ready_in  in  1  multiplier ready

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- Internal registers:
  - g: granted index.
  - last: previous grant; resets to N-1 so requester 0 wins first.
  - Operand latches for X, Y and round.
  - Result latches for P and OOR.
  - Watchdog counter wd.
- **IDLE**
  - When any req_valid_in bit and fpm_ready_in are high, the winner is the first valid index searched cyclically from last+1.
  - req_ready_out[winner] is driven combinationally in the same cycle.
  - At the clock edge: latch the winner's X, Y and round; g ← winner; go to ISSUE.
  - No grant while fpm_ready_in is low.
- **ISSUE**
  - fpm_start_out = 1 for exactly this one cycle.
  - fpm_x_out, fpm_y_out and fpm_round_out come from the latches. They are held stable in every state.
  - Next state is WAIT; wd ← 0.
- **WAIT**
  - wd increments each cycle.
  - The first WAIT cycle is blanked: a stale held fpm_valid_in is ignored there.
  - From the second WAIT cycle on, fpm_valid_in = 1 latches fpm_p_in and fpm_oor_in, then the FSM goes to RESP.
  - If wd reaches TIMEOUT with no qualified valid:
    - latch P = canonical quiet NaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (0x7FC0 for P=Q=8);
    - latch OOR = 4'b0010;
    - pulse err_out for one cycle;
    - go to RESP.
  - If qualified valid and timeout occur in the same cycle, valid wins and err_out stays low.
- **RESP**
  - resp_valid_out[g] = 1; resp_p_out and resp_oor_out come from the result latches.
  - When resp_ready_in[g] = 1: last ← g, go to IDLE.
  - resp_ready_in bits other than g are ignored.
- Requesters hold req_x_in, req_y_in and req_round_in stable while valid and not accepted.
- A request that drops valid before acceptance is never issued.

## Timing
- Reset (asynchronous, any state): state IDLE, last = N-1, all latches 0, wd 0.
  - Every output is 0, including fpm_start_out, err_out, busy_out and resp_p_out.
  - An in-flight operation is abandoned with no response.
  - The multiplier is reset separately.
- Accept to start: start is high in the cycle immediately after the accept edge.
- The multiplier samples start at the edge entering WAIT.
- If fpm_valid_in is first qualified in WAIT cycle k (k ≥ 2), resp_valid_out is high from the next cycle onward.
- Back-to-back throughput with the response consumed immediately: one operation per (3 + multiplier latency) cycles. This covers one IDLE cycle, one ISSUE cycle, the WAIT cycles and one RESP cycle.
- Fairness: a continuously valid requester waits at most N-1 other operations.

## Test plan
- Single request: requester 0 sends X=0x3FC0, Y=0x3FC0, round=0 → one start pulse with fpm_x_out=0x3FC0; response resp_valid_out=4'b0001, P=0x4010 (2.25), OOR=0.
- All four requesters valid with distinct operands (1.0×k, 0x3F80×0x4000 style) → grants in order 0,1,2,3,0; each response on the correct one-hot bit with the matching product.
- Stale valid: fpm_valid_in held high from the previous op during the first WAIT cycle, new result 3 cycles later → the result captured is the new one, not the stale one.
- Watchdog: fpm_valid_in held low → err_out pulses at wd=64; response P=0x7FC0, OOR=4'b0010; the next request proceeds normally.
- Backpressure: resp_ready_in low for 10 cycles → resp_valid_out and data held stable, no new accept, busy_out=1 throughout.
- Reset asserted mid-WAIT → all outputs 0 immediately; after release, requester 0 is granted first.
